// File: rtl/pwm_decoder.sv
// PWM-to-sample decoder: measures the high time in each PWM window and emits one
// sample per window with a valid strobe, a short-period flag and a lock indicator.
module pwm_decoder #(
  parameter int unsigned PERIOD      = 255,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] sample,
  output logic             sample_valid,
  output logic             period_err,
  output logic             locked
);

  localparam logic [CNT_W-1:0] PeriodVal = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] One       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MaxVal    = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    StSeek,
    StMeasure
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_d_q;
  logic                   rise;

  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] high_inc;
  logic [CNT_W-1:0] high_init;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q;
  logic             at_period;
  logic             close;

  // Input synchronizer; pwm_in is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d_q <= pwm_s;
    end
  end

  assign pwm_s     = sync_q[SYNC_STAGES-1];
  assign rise      = pwm_s & ~pwm_d_q;
  assign at_period = (period_cnt_q == PeriodVal);
  assign close     = rise | at_period;
  assign high_init = pwm_s ? One : '0;

  // Saturate so an over-long high time reads as full scale rather than wrapping.
  assign high_inc = (pwm_s && (high_cnt_q != MaxVal)) ? high_cnt_q + One : high_cnt_q;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      StSeek: begin
        if (close) begin
          state_d      = StMeasure;
          period_cnt_d = One;
          high_cnt_d   = high_init;
        end else begin
          period_cnt_d = period_cnt_q + One;
        end
      end
      StMeasure: begin
        if (close) begin
          // The closing cycle already belongs to the next window.
          sample_d     = high_cnt_q;
          valid_d      = 1'b1;
          err_d        = rise & (period_cnt_q < PeriodVal);
          period_cnt_d = One;
          high_cnt_d   = high_init;
        end else begin
          period_cnt_d = period_cnt_q + One;
          high_cnt_d   = high_inc;
        end
      end
      default: begin
        state_d = StSeek;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StSeek;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      locked_q     <= (state_d == StMeasure);
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign period_err   = err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: a PWM generator model drives pwm_in and
// decoded samples, strobe spacing, error flag and lock are checked.
`timescale 1ns/100ps
module tb_pwm_decoder;

  localparam int unsigned PERIOD = 255;
  localparam int unsigned CNT_W  = 8;

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] sample;
  logic             sample_valid;
  logic             period_err;
  logic             locked;

  int n_checks;
  int n_errors;

  // Generator model: counts 0..gen_per-1, out = count < level; level latched at wrap.
  logic gen_en;
  int   gen_per;
  int   gen_hi;
  int   gen_cur;
  int   gen_cnt;

  pwm_decoder #(
    .PERIOD      (PERIOD),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .period_err   (period_err),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pwm_in  = 1'b0;
    gen_cnt = 0;
    gen_cur = 0;
    forever begin
      @(negedge clk);
      if (!gen_en) begin
        pwm_in  = 1'b0;
        gen_cnt = 0;
        gen_cur = gen_hi;
      end else begin
        pwm_in = (gen_cnt < gen_cur);
        if (gen_cnt == gen_per - 1) begin
          gen_cnt = 0;
          gen_cur = gen_hi;
        end else begin
          gen_cnt++;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_sample"}, sample, 0);
    check_eq({tag, "_valid"}, sample_valid, 0);
    check_eq({tag, "_err"}, period_err, 0);
    check_eq({tag, "_locked"}, locked, 0);
  endtask

  task automatic reset_dut(input int per, input int hi);
    gen_en  = 1'b0;
    rst_n   = 1'b0;
    gen_per = per;
    gen_hi  = hi;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    #1;
    rst_n  = 1'b1;
    gen_en = 1'b1;
  endtask

  // Waits up to limit cycles for a strobe; cyc returns cycles waited.
  task automatic wait_strobe(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!sample_valid && cyc < limit);
    check_eq("strobe_seen", sample_valid, 1);
  endtask

  task automatic check_strobes(input string tag, input int n, input int exp_sample,
                               input int exp_err, input int exp_space);
    int cyc;
    for (int i = 0; i < n; i++) begin
      wait_strobe(exp_space + 5, cyc);
      check_eq({tag, "_sample"}, sample, exp_sample);
      check_eq({tag, "_err"}, period_err, exp_err);
      check_eq({tag, "_space"}, cyc, exp_space);
    end
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_errors = 0;
    gen_en   = 1'b0;
    gen_per  = 255;
    gen_hi   = 0;
    rst_n    = 1'b0;

    // Loopback, sample 128.
    reset_dut(255, 128);
    cyc = 0;
    while (!locked && cyc < PERIOD + 3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("lock128", locked, 1);
    wait_strobe(2 * PERIOD + 5, cyc);
    check_strobes("s128", 2, 128, 0, 255);
    @(posedge clk);
    #1;
    check_eq("pulse_width", sample_valid, 0);
    check_eq("sample_hold", sample, 128);
    wait_strobe(PERIOD + 5, cyc);
    check_eq("s128_space_after_hold", cyc + 1, 255);
    check_eq("s128_last", sample, 128);

    // Constant low: lock only by timeout.
    reset_dut(255, 0);
    repeat (250) @(posedge clk);
    #1;
    check_eq("low_not_locked_yet", locked, 0);
    cyc = 0;
    while (!locked && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("low_locked", locked, 1);
    wait_strobe(PERIOD + 5, cyc);
    check_eq("low_first_sample", sample, 0);
    check_strobes("low", 2, 0, 0, 255);

    // Constant high.
    reset_dut(255, 255);
    wait_strobe(PERIOD + 10, cyc);
    check_eq("high_first_sample", sample, 255);
    check_strobes("high", 2, 255, 0, 255);

    // Step 64 -> 200 mid-window.
    reset_dut(255, 64);
    wait_strobe(2 * PERIOD + 5, cyc);
    check_strobes("step64", 1, 64, 0, 255);
    repeat (100) @(posedge clk);
    gen_hi = 200;
    wait_strobe(PERIOD + 5, cyc);
    check_eq("step_transition_range", (sample >= 64 && sample <= 200) ? 1 : 0, 1);
    check_strobes("step200", 2, 200, 0, 255);

    // External PWM, period 100, high 30.
    reset_dut(100, 30);
    wait_strobe(2 * PERIOD + 5, cyc);
    check_strobes("ext", 3, 30, 1, 100);

    // Asynchronous reset pulse mid-window while locked.
    reset_dut(255, 128);
    wait_strobe(2 * PERIOD + 5, cyc);
    check_strobes("pre_rst", 1, 128, 0, 255);
    cyc = 0;
    while (gen_cnt != 200 && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    #3;
    rst_n = 1'b0;
    #0.5;
    check_outputs_zero("async_rst");
    #0.5;
    rst_n = 1'b1;
    #0.5;
    check_eq("relock_starts_unlocked", locked, 0);
    wait_strobe(2 * PERIOD + 5, cyc);
    check_eq("relocked", locked, 1);
    check_strobes("post_rst", 2, 128, 0, 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
- Recovers an 8-bit sample value from a PWM waveform by measuring the high time within each PWM period.
- Counterpart to the team's PWM generator, which has a 255-cycle period and drives `out = count < sample`. Used for loopback self-test and for decoding external PWM audio/control inputs into the sample domain.
- Outputs one sample per period, with a valid strobe and a period-error flag.

Parameters:
- PERIOD, 255: nominal PWM period in clk cycles. Must satisfy 2 <= PERIOD <= 2^CNT_W - 1.
- CNT_W, 8: width of the counters and of `sample`.
- SYNC_STAGES, 2: number of flops in the input synchronizer. Minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pwm_in  in  1  PWM input, asynchronous to clk
- sample  out  CNT_W  decoded high-cycle count of the last closed window
- sample_valid  out  1  one-cycle strobe; sample and period_err are updated on this cycle
- period_err  out  1  last window was closed by a rising edge before PERIOD cycles had elapsed
- locked  out  1  high while the FSM is in MEASURE

Behaviour:
- Reset: asynchronous on rst_n low. All flops clear to 0 and the FSM enters SEEK. While in reset: sample=0, sample_valid=0, period_err=0, locked=0. Reset release is synchronous to clk.
- Synchronizer: pwm_in passes through SYNC_STAGES flops to produce pwm_s. pwm_d is pwm_s delayed one cycle. rise = pwm_s & ~pwm_d.
- Counters, both CNT_W wide:
  - period_cnt counts cycles accumulated in the current window.
  - high_cnt counts cycles in the current window with pwm_s=1.
- SEEK state: wait for alignment.
  - Each cycle period_cnt increments.
  - On rise, or when period_cnt == PERIOD, go to MEASURE with period_cnt=1 and high_cnt=pwm_s.
  - No sample is emitted from SEEK.
- MEASURE state: close = rise | (period_cnt == PERIOD).
  - On close:
    - sample <= high_cnt (capped at 2^CNT_W - 1).
    - sample_valid <= 1.
    - period_err <= rise & (period_cnt < PERIOD).
    - period_cnt <= 1; high_cnt <= pwm_s. The current cycle belongs to the new window.
  - Otherwise: period_cnt <= period_cnt + 1; high_cnt <= high_cnt + pwm_s.
- Simultaneous events: if rise coincides with period_cnt == PERIOD, only one close occurs and period_err=0. This is the normal aligned case against the generator.
- No edges: with constant input, windows close every PERIOD cycles.
  - Constant low gives sample=0.
  - Constant high gives sample=PERIOD.
- Registered outputs:
  - sample and period_err hold their values between strobes.
  - sample_valid is high for exactly 1 cycle per close.
  - locked is registered as (state == MEASURE).
- Latency: pwm_in edge to pwm_s is SYNC_STAGES cycles. Close cycle to sample_valid is 1 cycle.
- MEASURE is only left by reset.

Test Plan:
- Loopback from the generator with sample=128, after reset release: locked=1 within PERIOD+3 cycles. Thereafter sample_valid pulses every 255 cycles with sample=128 and period_err=0.
- Generator sample=0 (constant-low input): lock by SEEK timeout after 255 cycles. Then sample=0 every 255 cycles, period_err=0.
- Generator sample=255 (constant-high input): sample=255 every 255 cycles, with no rises after the first.
- Step the generator from 64 to 200 mid-window: at most one transitional sample, between 64 and 200. All later samples are 200.
- External PWM, period 100, high 30: sample=30 and period_err=1 on every strobe after the first full window. The strobe spacing is 100 cycles.
- Assert rst_n low for 1 ns, asynchronously, mid-window in MEASURE: all outputs go to 0 immediately. After release, the FSM re-enters SEEK and relocks with correct samples.
